// File: rtl/shift_operand_unit_if.sv
// Request/response bundle between a shifter-operand client and shift_operand_unit.
// slave is the unit's view; master is the client's view.
interface shift_operand_unit_if #(
  parameter int WIDTH     = 32,
  parameter int OPERAND_W = 12,
  parameter int OP_TYPE_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_TYPE_W-1:0] optype;
  logic [OPERAND_W-1:0] operand;
  logic                 carry_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_carry;

  modport master (
    output in_valid, optype, operand, carry_in, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, optype, operand, carry_in, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/shift_operand_unit.sv
// Multi-cycle shifter-operand unit: reads Rm/Rs from a single-port register file,
// applies immediate, register-controlled or rotated-immediate shifts and holds the result.
`ifndef OP_DATA_SHIFT
`define OP_DATA_SHIFT    0
`define OP_DATA_ROR      1
`define OP_DATA_REGSHIFT 2
`define OP_LDSTR_IMM     3
`define OP_LDSTR_REG     4
`endif

module shift_operand_unit #(
  parameter int WIDTH     = 32,
  parameter int REGAW     = 4,
  parameter int OPERAND_W = 12,
  parameter int OP_TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shift_operand_unit_if.slave bus,
  output logic [REGAW-1:0]  rf_raddr,
  input  logic [WIDTH-1:0]  rf_rdata
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [OP_TYPE_W-1:0] OPC_SHIFT     = OP_TYPE_W'(`OP_DATA_SHIFT);
  localparam logic [OP_TYPE_W-1:0] OPC_ROR       = OP_TYPE_W'(`OP_DATA_ROR);
  localparam logic [OP_TYPE_W-1:0] OPC_REGSHIFT  = OP_TYPE_W'(`OP_DATA_REGSHIFT);
  localparam logic [OP_TYPE_W-1:0] OPC_LDSTR_IMM = OP_TYPE_W'(`OP_LDSTR_IMM);
  localparam logic [OP_TYPE_W-1:0] OPC_LDSTR_REG = OP_TYPE_W'(`OP_LDSTR_REG);

  typedef enum logic [2:0] {IDLE, RD_RM, RD_RS, SHIFT, OUT} state_t;

  state_t               state, state_nxt;
  logic [OP_TYPE_W-1:0] op_q;
  logic [OPERAND_W-1:0] operand_q;
  logic                 cin_q;
  logic [WIDTH-1:0]     rm_q;
  logic [7:0]           amt_q;
  logic [WIDTH:0]       res_w;
  logic [8:0]           amt_imm;
  logic                 accept;

  function automatic logic uses_rm(input logic [OP_TYPE_W-1:0] op);
    return (op == OPC_SHIFT) || (op == OPC_REGSHIFT) || (op == OPC_LDSTR_REG);
  endfunction

  // Returns {carry, data}; amount 0 passes rm with cin, large amounts saturate naturally
  // because the carry slot rides along as an extra bit of the shifted vector.
  function automatic logic [WIDTH:0] shift_by(input logic [1:0] sc, input logic [8:0] amt,
                                              input logic [WIDTH-1:0] rm, input logic cin);
    logic [WIDTH:0]        ext;
    logic signed [WIDTH:0] sext;
    logic [LW-1:0]         rot_amt;
    logic [WIDTH-1:0]      rot;
    ext     = '0;
    sext    = '0;
    rot_amt = amt[LW-1:0];
    rot     = rm;
    if (amt == '0) begin
      ext = {cin, rm};
    end else begin
      case (sc)
        2'b00: ext = {1'b0, rm} << amt;
        2'b01: begin
          ext = {rm, 1'b0} >> amt;
          ext = {ext[0], ext[WIDTH:1]};
        end
        2'b10: begin
          sext = $signed({rm, 1'b0}) >>> amt;
          ext  = {sext[0], sext[WIDTH:1]};
        end
        default: begin
          if (rot_amt != '0) rot = (rm >> rot_amt) | (rm << (WIDTH - int'(rot_amt)));
          ext = {rot[WIDTH-1], rot};
        end
      endcase
    end
    return ext;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    rf_raddr     = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = uses_rm(bus.optype) ? RD_RM : SHIFT;
      end
      RD_RM: begin
        rf_raddr  = REGAW'(operand_q[3:0]);
        state_nxt = (op_q == OPC_REGSHIFT) ? RD_RS : SHIFT;
      end
      RD_RS: begin
        rf_raddr  = REGAW'(operand_q[11:8]);
        state_nxt = SHIFT;
      end
      SHIFT: state_nxt = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign accept = (state == IDLE) && bus.in_valid && !flush;

  // Immediate shifts encode LSR/ASR #32 as imm5 == 0; ROR #0 (RRX) is handled separately.
  always_comb begin
    amt_imm = {4'd0, operand_q[11:7]};
    if (operand_q[11:7] == 5'd0 && (operand_q[6:5] == 2'b01 || operand_q[6:5] == 2'b10))
      amt_imm = 9'(WIDTH);
    res_w = {cin_q, {WIDTH{1'b0}}};
    case (op_q)
      OPC_SHIFT, OPC_LDSTR_REG: begin
        if (operand_q[11:7] == 5'd0 && operand_q[6:5] == 2'b11)
          res_w = {rm_q[0], cin_q, rm_q[WIDTH-1:1]};
        else
          res_w = shift_by(operand_q[6:5], amt_imm, rm_q, cin_q);
      end
      OPC_REGSHIFT:  res_w = shift_by(operand_q[6:5], {1'b0, amt_q}, rm_q, cin_q);
      OPC_ROR:       res_w = shift_by(2'b11, {4'd0, operand_q[11:8], 1'b0},
                                      WIDTH'(operand_q[7:0]), cin_q);
      OPC_LDSTR_IMM: res_w = {cin_q, WIDTH'(operand_q)};
      default:       res_w = {cin_q, {WIDTH{1'b0}}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      operand_q     <= '0;
      cin_q         <= 1'b0;
      rm_q          <= '0;
      amt_q         <= '0;
      bus.out_data  <= '0;
      bus.out_carry <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= bus.optype;
        operand_q <= bus.operand;
        cin_q     <= bus.carry_in;
      end
      if (state == RD_RM) rm_q  <= rf_rdata;
      if (state == RD_RS) amt_q <= rf_rdata[7:0];
      if (state == SHIFT) begin
        bus.out_data  <= res_w[WIDTH-1:0];
        bus.out_carry <= res_w[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_shift_operand_unit.sv
// Bench for shift_operand_unit: directed vector table, flush/reset sequences and
// randomized requests checked against a bit-serial shifter model.
`ifndef OP_DATA_SHIFT
`define OP_DATA_SHIFT    0
`define OP_DATA_ROR      1
`define OP_DATA_REGSHIFT 2
`define OP_LDSTR_IMM     3
`define OP_LDSTR_REG     4
`endif

module tb_shift_operand_unit;

  localparam logic [2:0] OPS  = 3'(`OP_DATA_SHIFT);
  localparam logic [2:0] OPR  = 3'(`OP_DATA_ROR);
  localparam logic [2:0] OPRS = 3'(`OP_DATA_REGSHIFT);
  localparam logic [2:0] OPLI = 3'(`OP_LDSTR_IMM);
  localparam logic [2:0] OPLR = 3'(`OP_LDSTR_REG);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] regs [16];

  int n_tests = 0;
  int n_fail  = 0;

  shift_operand_unit_if #(.WIDTH(32), .OPERAND_W(12), .OP_TYPE_W(3)) bus ();

  shift_operand_unit #(.WIDTH(32), .REGAW(4), .OPERAND_W(12), .OP_TYPE_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;
  assign rf_rdata = regs[rf_raddr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [11:0] opd;
    logic        cin;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] ed;
    logic        ec;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: shift one bit at a time, carry = last bit that fell off.
  function automatic logic [32:0] ref_model(input logic [2:0] op, input logic [11:0] opd,
                                            input logic cin);
    logic [31:0] v;
    logic        c;
    int          n;
    logic [1:0]  kind;
    v = '0; c = cin; n = 0; kind = opd[6:5];
    if (op == OPR) begin
      v = {24'd0, opd[7:0]};
      n = 2 * int'(opd[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      if (n != 0) c = v[31];
    end else if (op == OPLI) begin
      v = {20'd0, opd};
    end else if (op == OPS || op == OPRS || op == OPLR) begin
      v = regs[opd[3:0]];
      if (op == OPRS) n = int'(regs[opd[11:8]][7:0]);
      else begin
        n = int'(opd[11:7]);
        if (n == 0 && (kind == 2'b01 || kind == 2'b10)) n = 32;
      end
      if (op != OPRS && opd[11:7] == 5'd0 && kind == 2'b11) begin
        c = v[0];
        v = {cin, v[31:1]};
      end else begin
        for (int i = 0; i < n; i++) begin
          case (kind)
            2'b00: begin c = v[31]; v = v << 1; end
            2'b01: begin c = v[0];  v = v >> 1; end
            2'b10: begin c = v[0];  v = {v[31], v[31:1]}; end
            default: begin c = v[0]; v = {v[0], v[31:1]}; end
          endcase
        end
      end
    end
    return {c, v};
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    if (op == OPRS) return 3;
    if (op == OPS || op == OPLR) return 2;
    return 1;
  endfunction

  task automatic run_op(input string nm, input logic [2:0] op, input logic [11:0] opd,
                        input logic cin, input logic [31:0] ed, input logic ec,
                        input int lat_exp, input int hold);
    logic [31:0] held;
    int lat;
    @(negedge clk);
    check({nm, " in_ready_before"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1; bus.optype = op; bus.operand = opd; bus.carry_in = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.optype = 3'($urandom); bus.operand = 12'($urandom);
    bus.carry_in = ~cin;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(lat_exp));
    check({nm, " data"}, 64'(bus.out_data), 64'(ed));
    check({nm, " carry"}, 64'(bus.out_carry), 64'(ec));
    check({nm, " raddr_idle"}, 64'(rf_raddr), 64'(0));
    held = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, " hold_data"}, 64'(bus.out_data), 64'(held));
      check({nm, " hold_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({nm, " hold_valid"}, 64'(bus.out_valid), 64'(1));
    end
    @(negedge clk);
    check({nm, " in_ready_handoff"}, 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, " valid_after"}, 64'(bus.out_valid), 64'(0));
    check({nm, " in_ready_after"}, 64'(bus.in_ready), 64'(1));
  endtask

  task automatic no_valid_for(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check({nm, " spurious_valid"}, 64'(seen), 64'(0));
  endtask

  initial begin
    logic [32:0] r;
    logic [2:0]  op;
    logic [11:0] opd;
    logic        cin;

    bus.in_valid = 1'b0; bus.optype = '0; bus.operand = '0; bus.carry_in = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'(i) * 32'h0101_0101;

    vecs.push_back('{"lsl_imm4",     OPS,  12'h201, 1'b0, 32'h8000_0001, 32'h0, 32'h0000_0010, 1'b0, 2, 5});
    vecs.push_back('{"rs_lsr32",     OPRS, 12'h231, 1'b0, 32'h8000_0000, 32'd32, 32'h0, 1'b1, 3, 0});
    vecs.push_back('{"rs_lsr33",     OPRS, 12'h231, 1'b1, 32'h8000_0000, 32'd33, 32'h0, 1'b0, 3, 0});
    vecs.push_back('{"rrx",          OPS,  12'h061, 1'b1, 32'h0000_0003, 32'h0, 32'h8000_0001, 1'b1, 2, 1});
    vecs.push_back('{"ror_imm_r4",   OPR,  12'h4FF, 1'b0, 32'h0, 32'h0, 32'hFF00_0000, 1'b1, 1, 0});
    vecs.push_back('{"ror_imm_r0c0", OPR,  12'h0FF, 1'b0, 32'h0, 32'h0, 32'h0000_00FF, 1'b0, 1, 0});
    vecs.push_back('{"ror_imm_r0c1", OPR,  12'h0FF, 1'b1, 32'h0, 32'h0, 32'h0000_00FF, 1'b1, 1, 0});
    vecs.push_back('{"ldstr_imm",    OPLI, 12'hABC, 1'b1, 32'h0, 32'h0, 32'h0000_0ABC, 1'b1, 1, 0});
    vecs.push_back('{"bad_op5",      3'd5, 12'hFFF, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0});
    vecs.push_back('{"bad_op7",      3'd7, 12'h123, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 0});
    vecs.push_back('{"rs_lsl0",      OPRS, 12'h211, 1'b1, 32'h1234_5678, 32'h100, 32'h1234_5678, 1'b1, 3, 0});
    vecs.push_back('{"rs_lsl32",     OPRS, 12'h211, 1'b0, 32'h0000_0001, 32'd32, 32'h0, 1'b1, 3, 0});
    vecs.push_back('{"rs_lsl40",     OPRS, 12'h211, 1'b1, 32'hFFFF_FFFF, 32'd40, 32'h0, 1'b0, 3, 0});
    vecs.push_back('{"rs_asr40",     OPRS, 12'h251, 1'b0, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b1, 3, 0});
    vecs.push_back('{"rs_ror64",     OPRS, 12'h271, 1'b0, 32'h8000_0001, 32'd64, 32'h8000_0001, 1'b1, 3, 0});
    vecs.push_back('{"rs_ror36",     OPRS, 12'h271, 1'b0, 32'h0000_000F, 32'd36, 32'hF000_0000, 1'b1, 3, 0});
    vecs.push_back('{"rs_lsr4",      OPRS, 12'h231, 1'b0, 32'h0000_00F8, 32'd4, 32'h0000_000F, 1'b1, 3, 0});
    vecs.push_back('{"lsr_imm0",     OPS,  12'h021, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 2, 0});
    vecs.push_back('{"asr_imm0",     OPS,  12'h041, 1'b1, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0, 2, 0});
    vecs.push_back('{"lsr_imm1",     OPS,  12'h0A1, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_0001, 1'b1, 2, 0});
    vecs.push_back('{"ror_imm8",     OPS,  12'h461, 1'b0, 32'h0000_00AB, 32'h0, 32'hAB00_0000, 1'b1, 2, 0});
    vecs.push_back('{"ldstr_reg",    OPLR, 12'h101, 1'b0, 32'h4000_0001, 32'h0, 32'h0000_0004, 1'b1, 2, 0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'(0));
    check("rst out_data", 64'(bus.out_data), 64'(0));
    check("rst out_carry", 64'(bus.out_carry), 64'(0));
    check("rst rf_raddr", 64'(rf_raddr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst in_ready", 64'(bus.in_ready), 64'(1));

    foreach (vecs[k]) begin
      regs[vecs[k].opd[3:0]] = vecs[k].rm;
      if (vecs[k].op == OPRS) regs[vecs[k].opd[11:8]] = vecs[k].rs;
      run_op(vecs[k].nm, vecs[k].op, vecs[k].opd, vecs[k].cin, vecs[k].ed, vecs[k].ec,
             vecs[k].lat, vecs[k].hold);
    end

    // flush wins over in_valid in IDLE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.optype = OPLI; bus.operand = 12'h055; flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_idle in_ready", 64'(bus.in_ready), 64'(1));
    no_valid_for("flush_idle", 3);

    // flush while reading Rs
    regs[1] = 32'h0000_0F00; regs[2] = 32'd4;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.optype = OPRS; bus.operand = 12'h231; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flush_rs raddr_rm", 64'(rf_raddr), 64'(1));
    @(posedge clk); #1;
    check("flush_rs raddr_rs", 64'(rf_raddr), 64'(2));
    @(negedge clk);
    flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.out_ready = 1'b0;
    check("flush_rs in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_rs raddr", 64'(rf_raddr), 64'(0));
    no_valid_for("flush_rs", 5);
    run_op("after_flush", OPRS, 12'h231, 1'b0, 32'h0000_00F0, 1'b0, 3, 0);

    // asynchronous reset pulse while reading Rm
    regs[1] = 32'h0000_00F0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.optype = OPS; bus.operand = 12'h201; bus.carry_in = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rst_mid raddr_rm", 64'(rf_raddr), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid out_data", 64'(bus.out_data), 64'(0));
    check("rst_mid out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid raddr", 64'(rf_raddr), 64'(0));
    check("rst_mid in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid in_ready_edge", 64'(bus.in_ready), 64'(1));
    no_valid_for("rst_mid", 4);
    run_op("after_rst", OPS, 12'h201, 1'b1, 32'h0000_0F00, 1'b0, 2, 0);

    // randomized requests against the bit-serial model
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      op  = 3'($urandom_range(0, 7));
      opd = 12'($urandom);
      cin = 1'($urandom);
      if ($urandom_range(0, 1) == 1) regs[opd[11:8]] = 32'($urandom_range(0, 70));
      r = ref_model(op, opd, cin);
      run_op($sformatf("rnd%0d_op%0d_opd%03h", t, op, opd), op, opd, cin, r[31:0], r[32],
             ref_lat(op), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
